// File: rtl/dual_channel_collector_if.sv
// Handshake/bus bundle for dual_channel_collector: channel inputs, merged output,
// FIFO status flags and drop counter.
interface dual_channel_collector_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic              sel_q;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              x_full;
    logic              y_full;
    logic [7:0]        drop_cnt;

    modport master (
        output x_in, y_in, sel_q, in_valid, out_ready,
        input  out_data, out_ch, out_valid, x_full, y_full, drop_cnt
    );

    modport slave (
        input  x_in, y_in, sel_q, in_valid, out_ready,
        output out_data, out_ch, out_valid, x_full, y_full, drop_cnt
    );
endinterface

// File: rtl/dual_channel_collector.sv
// Merges X/Y channel words through two FIFOs into one round-robin output register.
// Define COLLECTOR_DROP_CNT_EN to build the saturating drop_cnt counter.
//
// state    | meaning
// S_EMPTY  | no word presented, out_valid=0
// S_LOADED | word presented on out_data/out_ch, out_valid=1
module dual_channel_collector #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    dual_channel_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [0:0] S_EMPTY  = 1'b0;
    localparam logic [0:0] S_LOADED = 1'b1;

    logic [DATA_W-1:0] mem_x [DEPTH];
    logic [DATA_W-1:0] mem_y [DEPTH];
    logic [AW-1:0]     wr_x, rd_x, wr_y, rd_y;
    logic [CW-1:0]     cnt_x, cnt_y;
    logic [CW-1:0]     cnt_x_nxt, cnt_y_nxt;
    logic [0:0]        state;
    logic              last_ch;
    logic [DATA_W-1:0] out_data_q;
    logic              out_ch_q;
    logic              x_full_q, y_full_q;

    logic x_ne, y_ne, x_at_full, y_at_full;
    logic take, pop_x, pop_y, push_x, push_y;

    assign x_ne      = (cnt_x != '0);
    assign y_ne      = (cnt_y != '0);
    assign x_at_full = (cnt_x == FULL_CNT);
    assign y_at_full = (cnt_y == FULL_CNT);

    // last_ch=0 means Y was popped last, so X takes the tie.
    assign take   = (state == S_EMPTY) || bus.out_ready;
    assign pop_x  = take && x_ne && (!y_ne || !last_ch);
    assign pop_y  = take && y_ne && !pop_x;
    // A full FIFO still accepts a push when it is popped on the same edge.
    assign push_x = bus.in_valid &&  bus.sel_q && (!x_at_full || pop_x);
    assign push_y = bus.in_valid && !bus.sel_q && (!y_at_full || pop_y);

    assign cnt_x_nxt = cnt_x + CW'(push_x) - CW'(pop_x);
    assign cnt_y_nxt = cnt_y + CW'(push_y) - CW'(pop_y);

    always_ff @(posedge clk) begin
        if (push_x) mem_x[wr_x] <= bus.x_in;
        if (push_y) mem_y[wr_y] <= bus.y_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_x       <= '0;
            rd_x       <= '0;
            wr_y       <= '0;
            rd_y       <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
            x_full_q   <= 1'b0;
            y_full_q   <= 1'b0;
            state      <= S_EMPTY;
            last_ch    <= 1'b0;
            out_data_q <= '0;
            out_ch_q   <= 1'b0;
        end else begin
            if (push_x) wr_x <= wr_x + AW'(1);
            if (push_y) wr_y <= wr_y + AW'(1);
            cnt_x    <= cnt_x_nxt;
            cnt_y    <= cnt_y_nxt;
            x_full_q <= (cnt_x_nxt == FULL_CNT);
            y_full_q <= (cnt_y_nxt == FULL_CNT);

            if (pop_x) begin
                out_data_q <= mem_x[rd_x];
                out_ch_q   <= 1'b1;
                last_ch    <= 1'b1;
                rd_x       <= rd_x + AW'(1);
            end else if (pop_y) begin
                out_data_q <= mem_y[rd_y];
                out_ch_q   <= 1'b0;
                last_ch    <= 1'b0;
                rd_y       <= rd_y + AW'(1);
            end

            if (pop_x || pop_y) begin
                state <= S_LOADED;
            end else if (bus.out_ready) begin
                state <= S_EMPTY;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = (state == S_LOADED);
    assign bus.x_full    = x_full_q;
    assign bus.y_full    = y_full_q;

`ifdef COLLECTOR_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_q;

    assign drop = bus.in_valid && !(bus.sel_q ? push_x : push_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dual_channel_collector.sv
// Self-checking bench for dual_channel_collector: vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_dual_channel_collector;
    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
`ifdef COLLECTOR_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dual_channel_collector_if #(.DATA_W(DATA_W)) bus ();

    dual_channel_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: two bounded queues plus a single presented word.
    logic [DATA_W-1:0] qx[$];
    logic [DATA_W-1:0] qy[$];
    bit                m_valid;
    logic [DATA_W-1:0] m_word;
    bit                m_ch;
    bit                m_last;
    int                m_drop;

    task automatic model_reset();
        qx.delete();
        qy.delete();
        m_valid = 0;
        m_word  = '0;
        m_ch    = 0;
        m_last  = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge(input logic [DATA_W-1:0] xi, yi, input bit sel, v, rdy);
        int nx, ny;
        bit px;
        bit py;
        nx = qx.size();
        ny = qy.size();
        px = 0;
        py = 0;
        if (!m_valid || rdy) begin
            if (nx > 0 && (ny == 0 || !m_last)) begin
                m_word = qx.pop_front(); m_ch = 1; m_last = 1; m_valid = 1; px = 1;
            end else if (ny > 0) begin
                m_word = qy.pop_front(); m_ch = 0; m_last = 0; m_valid = 1; py = 1;
            end else begin
                m_valid = 0;
            end
        end
        if (v) begin
            if (sel) begin
                if (nx - int'(px) < DEPTH) qx.push_back(xi);
                else if (m_drop < 255) m_drop++;
            end else begin
                if (ny - int'(py) < DEPTH) qy.push_back(yi);
                else if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic check_model();
        check("model_out_valid", bus.out_valid, m_valid);
        check("model_out_data", bus.out_data, m_word);
        check("model_out_ch", bus.out_ch, m_ch);
        check("model_x_full", bus.x_full, qx.size() == DEPTH);
        check("model_y_full", bus.y_full, qy.size() == DEPTH);
        check("model_drop_cnt", bus.drop_cnt, DROP_EN ? m_drop : 0);
    endtask

    task automatic step(input logic [DATA_W-1:0] xi, yi, input bit sel, v, rdy);
        bus.x_in      = xi;
        bus.y_in      = yi;
        bus.sel_q     = sel;
        bus.in_valid  = v;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(xi, yi, sel, v, rdy);
        #1;
        check_model();
    endtask

    task automatic idle(input bit rdy);
        step('0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic expect_out(input string nm, input bit v, input logic [DATA_W-1:0] d, input bit ch);
        check({nm, "_valid"}, bus.out_valid, v);
        if (v) begin
            check({nm, "_data"}, bus.out_data, d);
            check({nm, "_ch"}, bus.out_ch, ch);
        end
    endtask

    // Asserts reset away from a clock edge and checks outputs clear without an edge.
    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_x_full", bus.x_full, 0);
        check("rst_y_full", bus.y_full, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] xi;
        logic [DATA_W-1:0] yi;
        bit                sel;
        bit                v;
        bit                rdy;
        bit                e_valid;
        logic [DATA_W-1:0] e_data;
        bit                e_ch;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int w;
        int last_w;

        // Single word 0x155 then alternation of words 1..8 (odd -> X, even -> Y).
        vecs[0] = '{xi: 10'h155, yi: 10'h2AA, sel: 1'b1, v: 1'b1, rdy: 1'b1, e_valid: 1'b0, e_data: 10'h000, e_ch: 1'b0};
        vecs[1] = '{xi: 10'h000, yi: 10'h000, sel: 1'b0, v: 1'b0, rdy: 1'b1, e_valid: 1'b1, e_data: 10'h155, e_ch: 1'b1};
        vecs[2] = '{xi: 10'h000, yi: 10'h000, sel: 1'b0, v: 1'b0, rdy: 1'b1, e_valid: 1'b0, e_data: 10'h155, e_ch: 1'b1};
        for (int j = 0; j < 10; j++) begin
            w = j + 1;
            vecs[3+j].v   = (j < 8);
            vecs[3+j].sel = w[0];
            vecs[3+j].xi  = w[0] ? DATA_W'(w) : 10'h3FF;
            vecs[3+j].yi  = w[0] ? 10'h3FF : DATA_W'(w);
            vecs[3+j].rdy = 1'b1;
            vecs[3+j].e_valid = (j >= 1 && j <= 8);
            last_w = (j == 0) ? 'h155 : ((j <= 8) ? j : 8);
            vecs[3+j].e_data = DATA_W'(last_w);
            vecs[3+j].e_ch   = (j == 0) ? 1'b1 : last_w[0];
        end

        bus.x_in = '0; bus.y_in = '0; bus.sel_q = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #2;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].xi, vecs[i].yi, vecs[i].sel, vecs[i].v, vecs[i].rdy);
            check($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].e_data);
            check($sformatf("vec%0d_ch", i), bus.out_ch, vecs[i].e_ch);
        end

        // Backpressure and overflow: six words into X with the consumer stalled.
        do_reset();
        for (int i = 1; i <= 6; i++) step(DATA_W'(i), '0, 1'b1, 1'b1, 1'b0);
        check("ovf_x_full", bus.x_full, 1);
        check("ovf_drop_cnt", bus.drop_cnt, DROP_EN ? 1 : 0);
        expect_out("ovf_hold", 1'b1, 10'd1, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            idle(1'b1);
            expect_out($sformatf("ovf_out%0d", i), 1'b1, DATA_W'(i), 1'b1);
        end
        idle(1'b1);
        expect_out("ovf_drained", 1'b0, '0, 1'b0);

        // Round-robin: A1,B1,A2,B2 preloaded, then released.
        do_reset();
        step(10'h0A1, '0, 1'b1, 1'b1, 1'b0);
        step('0, 10'h0B1, 1'b0, 1'b1, 1'b0);
        step(10'h0A2, '0, 1'b1, 1'b1, 1'b0);
        step('0, 10'h0B2, 1'b0, 1'b1, 1'b0);
        expect_out("rr_first", 1'b1, 10'h0A1, 1'b1);
        idle(1'b1);
        expect_out("rr_b1", 1'b1, 10'h0B1, 1'b0);
        idle(1'b1);
        expect_out("rr_a2", 1'b1, 10'h0A2, 1'b1);
        idle(1'b1);
        expect_out("rr_b2", 1'b1, 10'h0B2, 1'b0);
        idle(1'b1);
        expect_out("rr_empty", 1'b0, '0, 1'b0);

        // Full FIFO with simultaneous pop accepts the push.
        do_reset();
        for (int i = 1; i <= 5; i++) step(DATA_W'(i), '0, 1'b1, 1'b1, 1'b0);
        check("fp_pre_full", bus.x_full, 1);
        step(10'd6, '0, 1'b1, 1'b1, 1'b1);
        check("fp_x_full", bus.x_full, 1);
        check("fp_drop_cnt", bus.drop_cnt, 0);
        expect_out("fp_out2", 1'b1, 10'd2, 1'b1);
        for (int i = 3; i <= 6; i++) begin
            idle(1'b1);
            expect_out($sformatf("fp_out%0d", i), 1'b1, DATA_W'(i), 1'b1);
        end

        // Reset mid-stream with words buffered and one presented.
        do_reset();
        for (int i = 1; i <= 3; i++) step(DATA_W'(i + 16), '0, 1'b1, 1'b1, 1'b0);
        expect_out("mid_before", 1'b1, 10'd17, 1'b1);
        do_reset();
        idle(1'b1);
        expect_out("mid_after", 1'b0, '0, 1'b0);
        step(10'h123, '0, 1'b1, 1'b1, 1'b1);
        expect_out("mid_lat_k", 1'b0, '0, 1'b0);
        idle(1'b1);
        expect_out("mid_lat_k1", 1'b1, 10'h123, 1'b1);
        idle(1'b1);

        // Randomized traffic: stalled-heavy first half, free-flowing second half.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit rdy;
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, rdy);
        end

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) step(DATA_W'(i), '0, 1'b1, 1'b1, 1'b0);
        check("drop_saturate", bus.drop_cnt, DROP_EN ? 255 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
